// File: rtl/cxu_host_pkg.sv
// Shared widths, defaults and FSM encoding for the CXU host adapter.
package cxu_host_pkg;

    localparam int FUNC_W         = 3;
    localparam int STATE_ID_W     = 3;
    localparam int CXU_ID_W       = 4;
    localparam int DATA_W         = 32;
    localparam int CNT_W          = 8;
    localparam int STATE_W_DEF    = 2048;
    localparam int NUM_STATES_DEF = 8;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } state_e;

endpackage

// File: rtl/cxu_state_bank.sv
// Per-context state storage: async-cleared register bank with one write
// port and one combinational read port.
module cxu_state_bank
    import cxu_host_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int STATE_W    = STATE_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [STATE_ID_W-1:0] waddr_i,
    input  logic [STATE_W-1:0]    wdata_i,
    input  logic [STATE_ID_W-1:0] raddr_i,
    output logic [STATE_W-1:0]    rdata_o
);

    localparam int AW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
    localparam logic [STATE_ID_W:0] NS_LIM = NUM_STATES[STATE_ID_W:0];

    logic [STATE_W-1:0] mem_q [NUM_STATES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

    // Out-of-range ids (rejected requests) read as zero rather than aliasing.
    assign rdata_o = ({1'b0, raddr_i} < NS_LIM) ? mem_q[raddr_i[AW-1:0]] : '0;

endmodule

// File: rtl/cxu_host_adapter.sv
// CPU-side initiator for a single CXU: one request in flight, command/response
// sequencing with timeout, and ownership of the per-context state bank.
module cxu_host_adapter
    import cxu_host_pkg::*;
#(
    parameter int NUM_STATES = NUM_STATES_DEF,
    parameter int STATE_W    = STATE_W_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FUNC_W-1:0]     req_function_id,
    input  logic [DATA_W-1:0]     req_inputs_0,
    input  logic [DATA_W-1:0]     req_inputs_1,
    input  logic [STATE_ID_W-1:0] req_state_id,
    input  logic [CXU_ID_W-1:0]   req_cxu_id,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_outputs_0,
    output logic                  resp_error,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [FUNC_W-1:0]     cmd_payload_function_id,
    output logic [DATA_W-1:0]     cmd_payload_inputs_0,
    output logic [DATA_W-1:0]     cmd_payload_inputs_1,
    output logic [STATE_ID_W-1:0] cmd_payload_state_id,
    output logic [CXU_ID_W-1:0]   cmd_payload_cxu_id,
    output logic                  cmd_payload_ready,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [DATA_W-1:0]     rsp_payload_outputs_0,
    input  logic                  rsp_payload_ready,
    output logic [STATE_W-1:0]    state_read,
    input  logic [STATE_W-1:0]    state_write,
    input  logic                  state_write_en
);

    localparam logic [CNT_W-1:0]    TO_LIM = TIMEOUT[CNT_W-1:0];
    localparam logic [STATE_ID_W:0] NS_LIM = NUM_STATES[STATE_ID_W:0];

    state_e                state_q;
    logic                  req_ready_q, cmd_valid_q, rsp_ready_q;
    logic                  resp_valid_q, resp_error_q;
    logic [DATA_W-1:0]     resp_out_q, in0_q, in1_q;
    logic [FUNC_W-1:0]     func_q;
    logic [STATE_ID_W-1:0] sid_q;
    logic [CXU_ID_W-1:0]   cxu_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  bank_we;
    logic                  unused_rsp_payload_ready;

    assign unused_rsp_payload_ready = rsp_payload_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b0;
            cmd_valid_q  <= 1'b0;
            rsp_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_out_q   <= '0;
            func_q       <= '0;
            in0_q        <= '0;
            in1_q        <= '0;
            sid_q        <= '0;
            cxu_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        func_q      <= req_function_id;
                        in0_q       <= req_inputs_0;
                        in1_q       <= req_inputs_1;
                        sid_q       <= req_state_id;
                        cxu_q       <= req_cxu_id;
                        // Bad context ids are answered locally; the CXU never sees them.
                        if ({1'b0, req_state_id} >= NS_LIM) begin
                            resp_out_q   <= '0;
                            resp_error_q <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= RESP;
                        end else begin
                            cmd_valid_q <= 1'b1;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        rsp_ready_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        resp_out_q   <= rsp_payload_outputs_0;
                        resp_error_q <= 1'b0;
                        rsp_ready_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (cnt_q == TO_LIM) begin
                        resp_out_q   <= '0;
                        resp_error_q <= 1'b1;
                        rsp_ready_q  <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_error_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // State is committed only together with an accepted response.
    assign bank_we = (state_q == WAIT_RSP) && rsp_valid && state_write_en;

    cxu_state_bank #(
        .NUM_STATES (NUM_STATES),
        .STATE_W    (STATE_W)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bank_we),
        .waddr_i (sid_q),
        .wdata_i (state_write),
        .raddr_i (sid_q),
        .rdata_o (state_read)
    );

    assign req_ready               = req_ready_q;
    assign cmd_valid               = cmd_valid_q;
    assign cmd_payload_ready       = cmd_valid_q;
    assign cmd_payload_function_id = func_q;
    assign cmd_payload_inputs_0    = in0_q;
    assign cmd_payload_inputs_1    = in1_q;
    assign cmd_payload_state_id    = sid_q;
    assign cmd_payload_cxu_id      = cxu_q;
    assign rsp_ready               = rsp_ready_q;
    assign resp_valid              = resp_valid_q;
    assign resp_error              = resp_error_q;
    assign resp_outputs_0          = resp_out_q;

endmodule

// File: doc/cxu_host_adapter.md
# cxu_host_adapter

Initiator side of the CXU command/response interface: accepts one custom-instruction request at a time from the CPU pipeline, drives the `cmd_*` channel into a CXU, collects `rsp_*`, and returns the result to the CPU. Owns the per-context state bank: it presents `state_read` for the addressed `state_id` and commits `state_write` when the CXU asserts `state_write_en`. Sits between the CPU custom-instruction port and a single CXU instance.

## Interface
- `NUM_STATES`, 8: state contexts held; `state_id` range 0..NUM_STATES-1.
- `STATE_W`, 2048: bits per state context.
- `TIMEOUT`, 255: max cycles in WAIT_RSP before error; width 8 bits.
- `clk`  in  1  clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all registers and state bank.
- `req_valid` / `req_ready`  in / out  1  CPU request handshake.
- `req_function_id`  in  3; `req_inputs_0`, `req_inputs_1`  in  32; `req_state_id`  in  3; `req_cxu_id`  in  4.
- `resp_valid` / `resp_ready`  out / in  1  CPU response handshake.
- `resp_outputs_0`  out  32  result; `resp_error`  out  1  timeout or bad state_id.
- `cmd_valid` / `cmd_ready`  out / in  1; `cmd_payload_function_id`  out  3; `cmd_payload_inputs_0`, `cmd_payload_inputs_1`  out  32; `cmd_payload_state_id`  out  3; `cmd_payload_cxu_id`  out  4; `cmd_payload_ready`  out  1.
- `rsp_valid` / `rsp_ready`  in / out  1; `rsp_payload_outputs_0`  in  32; `rsp_payload_ready`  in  1 (ignored).
- `state_read`  out  STATE_W  bank[registered state_id].
- `state_write`  in  STATE_W; `state_write_en`  in  1.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RSP, RESP.
- IDLE: `req_ready`=1. On `req_valid`: register all req fields. If `req_state_id` >= NUM_STATES -> RESP with `resp_error`=1, outputs 0, no cmd issued. Else -> ISSUE.
- ISSUE: `cmd_valid`=1, `cmd_payload_ready`=1, payload from registers. On `cmd_ready` -> WAIT_RSP, timeout counter cleared to 0.
- WAIT_RSP: `rsp_ready`=1. On `rsp_valid`: capture `rsp_payload_outputs_0`; if `state_write_en` same cycle, write `state_write` into bank[state_id]; -> RESP, error=0. Else counter increments; when counter == TIMEOUT and no `rsp_valid` -> RESP, error=1, outputs 0, no bank write.
- `state_write_en` outside the WAIT_RSP accepting cycle is ignored.
- RESP: `resp_valid`=1, holds `resp_outputs_0`/`resp_error` stable; on `resp_ready` -> IDLE.
- `state_read` is combinational from bank using the registered state_id; valid from ISSUE through WAIT_RSP.

## Timing
- Reset values: `req_ready`=0 during reset, 1 in IDLE after; `cmd_valid`, `cmd_payload_ready`, `rsp_ready`, `resp_valid`, `resp_error`=0; all payload outputs and `resp_outputs_0`=0; bank all zeros, so `state_read`=0.
- Against an always-ready/always-valid CXU: req accept cycle N, cmd fire N+1, rsp fire N+2, `resp_valid` N+3. Minimum request-to-request spacing 4 cycles with `resp_ready` held high.
- `rsp_valid` is never sampled in ISSUE, even if high same cycle as cmd fire.
- Bank write takes effect next cycle; visible to the following request.
- Timeout: error `resp_valid` exactly TIMEOUT+2 cycles after cmd fire.
- Reset mid-operation: FSM to IDLE immediately, pending request dropped, bank cleared.

## Structure
- Package `cxu_host_pkg`: FSM state enum, field widths (FUNC_W=3, STATE_ID_W=3, CXU_ID_W=4, DATA_W=32), STATE_W default.
- Sub-module `cxu_state_bank`: NUM_STATES x STATE_W registers, async clear, one write port, one combinational read port.

## Test plan
- Always-ready CXU echoing inputs_0+inputs_1: req (3, 5) state 0 -> `resp_outputs_0`=8, error 0, `resp_valid` at N+3.
- Byte-increment CXU, inputs (10,10), state 2, `state_write_en`=1 -> next req on state 2 sees every byte of `state_read` = 0x01; state 3 still all zero.
- CXU holds `cmd_ready`=0 for 5 cycles, `rsp_valid` delayed 7 -> correct result, payload stable while stalled.
- CXU never responds, TIMEOUT=255 -> `resp_error`=1, outputs 0, bank unchanged.
- `req_state_id`=7 with NUM_STATES=4 -> immediate error response, `cmd_valid` never asserted.
- Assert `reset` during WAIT_RSP after a committed write -> all outputs at reset values, `state_read`=0, next request completes normally.
